// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes (including the DIV/DIVU extension),
// divider state encoding and overflow-flag bit positions.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001,
      OP_DIV  = 4'b1110,
      OP_DIVU = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   localparam int OV_SIGNED   = 1;
   localparam int OV_CARRY_DZ = 0;

   function automatic logic [1:0] ov_flags(input logic divZero, input logic signedOvf);
      logic [1:0] f;
      f              = '0;
      f[OV_SIGNED]   = signedOvf;
      f[OV_CARRY_DZ] = divZero;
      return f;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract division step; purely combinational.
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic             qBit;

   // The extra top bit of trial acts as the borrow that decides restore vs. keep.
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      trial   = shifted - {2'b00, div_i};
      qBit    = ~trial[WIDTH+1];
      rem_o   = qBit ? trial[WIDTH:0] : shifted[WIDTH:0];
      quo_o   = {quo_i[WIDTH-2:0], qBit};
   end

endmodule

// File: rtl/alu_div.sv
// Multi-cycle signed/unsigned restoring divider (IDLE->CALC->FIX->DONE).
// Define DIV_ZERO_FAST_EN to let divide-by-zero skip straight to DONE.
module alu_div
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [1:0]       ov
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] aOrig_q, aOrig_d;
   logic             negQ_q, negQ_d;
   logic             negR_q, negR_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] y0_q, y0_d;
   logic [WIDTH-1:0] y1_q, y1_d;
   logic [1:0]       ov_q, ov_d;

   logic [WIDTH-1:0] magA, magB;
   logic [WIDTH:0]   stepRem;
   logic [WIDTH-1:0] stepQuo;
   logic [WIDTH-1:0] remLow;

   // The most negative value negates to itself, which is still the right unsigned magnitude.
   assign magA   = (signed_op && A[WIDTH-1]) ? -A : A;
   assign magB   = (signed_op && B[WIDTH-1]) ? -B : B;
   assign remLow = rem_q[WIDTH-1:0];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (div_q),
      .rem_o (stepRem),
      .quo_o (stepQuo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      aOrig_d = aOrig_q;
      negQ_d  = negQ_q;
      negR_d  = negR_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      ov_d    = ov_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               aOrig_d = A;
               quo_d   = magA;
               div_d   = magB;
               rem_d   = '0;
               cnt_d   = '0;
               negQ_d  = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
               negR_d  = signed_op && A[WIDTH-1];
               dz_d    = (B == '0);
               ovf_d   = signed_op && (A == MOST_NEG) && (B == '1);
`ifdef DIV_ZERO_FAST_EN
               if (B == '0) begin
                  state_d = DONE;
                  y0_d    = '1;
                  y1_d    = A;
                  ov_d    = ov_flags(1'b1, 1'b0);
               end else begin
                  state_d = CALC;
               end
`else
               state_d = CALC;
`endif
            end
         end
         CALC: begin
            rem_d = stepRem;
            quo_d = stepQuo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = DONE;
            ov_d    = ov_flags(dz_q, ovf_q);
            if (dz_q) begin
               y0_d = '1;
               y1_d = aOrig_q;
            end else if (ovf_q) begin
               y0_d = aOrig_q;
               y1_d = '0;
            end else begin
               y0_d = negQ_q ? -quo_q : quo_q;
               y1_d = negR_q ? -remLow : remLow;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         aOrig_q <= '0;
         negQ_q  <= 1'b0;
         negR_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         y0_q    <= '0;
         y1_q    <= '0;
         ov_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         aOrig_q <= aOrig_d;
         negQ_q  <= negQ_d;
         negR_q  <= negR_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         ov_q    <= ov_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign y0   = y0_q;
   assign y1   = y1_q;
   assign ov   = ov_q;

endmodule

// File: tb/tb_alu_div.sv
// Directed + random scoreboard bench for alu_div (WIDTH=4).
module tb_alu_div;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             signed_op = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             busy, done;
   logic [WIDTH-1:0] y0, y1;
   logic [1:0]       ov;

   int total = 0;
   int bad   = 0;
   int seen;
   logic [3:0] ra, rb;
   logic       rs;

   typedef struct {
      logic [3:0] y0;
      logic [3:0] y1;
      logic [1:0] ov;
      int         lat;
   } exp_t;

   exp_t sb[$];

`ifdef DIV_ZERO_FAST_EN
   localparam int DZ_LAT = 1;
`else
   localparam int DZ_LAT = 6;
`endif

   alu_div #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .signed_op (signed_op),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .y0        (y0),
      .y1        (y1),
      .ov        (ov)
   );

   always #5 clk = ~clk;

   // Independent reference: language arithmetic plus the two special cases.
   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic s);
      exp_t e;
      int   sa, sd;
      e.lat = 6;
      if (b == 4'd0) begin
         e.y0  = 4'hF;
         e.y1  = a;
         e.ov  = 2'b01;
         e.lat = DZ_LAT;
      end else if (s && a == 4'b1000 && b == 4'b1111) begin
         e.y0 = a;
         e.y1 = 4'd0;
         e.ov = 2'b10;
      end else if (s) begin
         sa   = $signed(a);
         sd   = $signed(b);
         e.y0 = 4'(sa / sd);
         e.y1 = 4'(sa % sd);
         e.ov = 2'b00;
      end else begin
         e.y0 = a / b;
         e.y1 = a % b;
         e.ov = 2'b00;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic s,
                                input exp_t e, input bit push);
      @(negedge clk);
      A = a;
      B = b;
      signed_op = s;
      start = 1'b1;
      if (push) sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Waits (bounded) for done, then compares against the oldest scoreboard entry.
   task automatic waitDone(input string tag, input int startCyc);
      exp_t e;
      int   cyc;
      cyc = startCyc;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
      end while (!done && cyc < 20);
      check({tag, ".pending"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, ".lat"}, 32'(cyc), 32'(e.lat));
         check({tag, ".y0"}, 32'(y0), 32'(e.y0));
         check({tag, ".y1"}, 32'(y1), 32'(e.y1));
         check({tag, ".ov"}, 32'(ov), 32'(e.ov));
      end
   endtask

   task automatic checkOutput(input string tag, input int startCyc);
      waitDone(tag, startCyc);
      @(negedge clk);
      check({tag, ".donePulse"}, 32'(done), 32'd0);
      check({tag, ".idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.y0", 32'(y0), 32'd0);
      check("rst.y1", 32'(y1), 32'd0);
      check("rst.ov", 32'(ov), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      rst_n = 1'b1;

      // Directed vectors
      applyStimulus(4'd13, 4'd3, 1'b0, '{4'd4, 4'd1, 2'b00, 6}, 1'b1);
      checkOutput("udiv13_3", 0);
      applyStimulus(4'b1001, 4'd2, 1'b1, '{4'b1101, 4'b1111, 2'b00, 6}, 1'b1);
      checkOutput("sdivm7_2", 0);
      applyStimulus(4'b1000, 4'b1111, 1'b1, '{4'b1000, 4'b0000, 2'b10, 6}, 1'b1);
      checkOutput("sovf", 0);
      applyStimulus(4'd5, 4'd0, 1'b0, '{4'hF, 4'd5, 2'b01, DZ_LAT}, 1'b1);
      checkOutput("udz", 0);
      applyStimulus(4'd5, 4'd0, 1'b1, '{4'hF, 4'd5, 2'b01, DZ_LAT}, 1'b1);
      checkOutput("sdz", 0);
      applyStimulus(4'b1001, 4'd0, 1'b1, '{4'hF, 4'b1001, 2'b01, DZ_LAT}, 1'b1);
      checkOutput("sdzneg", 0);

      // start pulsed during CALC must be ignored
      applyStimulus(4'd13, 4'd3, 1'b0, '{4'd4, 4'd1, 2'b00, 6}, 1'b1);
      @(negedge clk);
      A = 4'd9;
      B = 4'd2;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      checkOutput("calcPulse", 1);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("calcPulse.stray", 32'(seen), 32'd0);

      // start held through DONE: accepted again in the following IDLE cycle
      @(negedge clk);
      A = 4'd7;
      B = 4'd2;
      signed_op = 1'b0;
      start = 1'b1;
      sb.push_back('{4'd3, 4'd1, 2'b00, 6});
      @(posedge clk);
      #1;
      A = 4'b1001;
      B = 4'd3;
      signed_op = 1'b1;
      waitDone("held1", 0);
      sb.push_back('{4'b1110, 4'b1111, 2'b00, 6});
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      checkOutput("held2", 0);

      // Reset in the middle of a division aborts it
      applyStimulus(4'd9, 4'd2, 1'b0, model(4'd9, 4'd2, 1'b0), 1'b0);
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midRst.y0", 32'(y0), 32'd0);
      check("midRst.y1", 32'(y1), 32'd0);
      check("midRst.ov", 32'(ov), 32'd0);
      check("midRst.busy", 32'(busy), 32'd0);
      check("midRst.done", 32'(done), 32'd0);
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("midRst.noDone", 32'(seen), 32'd0);
      applyStimulus(4'd9, 4'd2, 1'b0, '{4'd4, 4'd1, 2'b00, 6}, 1'b1);
      checkOutput("postRst", 0);

      // Random vectors against the reference model
      for (int i = 0; i < 10; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rs = 1'($urandom_range(0, 1));
         applyStimulus(ra, rb, rs, model(ra, rb, rs), 1'b1);
         checkOutput($sformatf("rand%0d", i), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only when idle.
REQ-005 The block SHALL have port signed_op, input, 1 bit: 1 = two's-complement division, 0 = unsigned division; sampled with start.
REQ-006 The block SHALL have ports A and B, input, WIDTH bits each: dividend A and divisor B; sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have port y0, output, WIDTH bits: quotient.
REQ-010 The block SHALL have port y1, output, WIDTH bits: remainder.
REQ-011 The block SHALL have port ov, output, 2 bits: ov[1] = signed overflow, ov[0] = divide-by-zero.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-013 IDLE SHALL go to CALC on the edge where start=1; operands and signed_op are captured on that edge.
REQ-014 start SHALL be ignored whenever state != IDLE.
REQ-015 In signed mode, operands SHALL be converted to magnitudes on capture; in unsigned mode they SHALL be used unchanged.
REQ-016 CALC SHALL perform exactly WIDTH restoring shift-subtract steps, one per cycle, tracked by a step counter of $clog2(WIDTH+1) bits.
REQ-017 After the last step, CALC SHALL go to FIX.
REQ-018 In signed mode, FIX SHALL negate the quotient when the operand signs differ, and negate the remainder when A was negative (truncation toward zero).
REQ-019 FIX SHALL go to DONE; DONE SHALL go to IDLE after one cycle.
REQ-020 done SHALL be high only in DONE, i.e. exactly one cycle, WIDTH+2 cycles after the accepting edge (6 for WIDTH=4).
REQ-021 busy SHALL be high in CALC, FIX and DONE, and low in IDLE.
REQ-022 y0, y1 and ov SHALL be registered, updated only on entry to DONE, and held until the next completion.
REQ-023 start=1 in the DONE cycle SHALL be ignored; start is accepted again in the following IDLE cycle.
REQ-024 Divide-by-zero (B=0) SHALL give y0 = all ones, y1 = A, ov = 2'b01, in both modes.
REQ-025 Signed overflow (A = most negative value, B = -1, signed_op=1) SHALL give y0 = A, y1 = 0, ov = 2'b10.
REQ-026 For all other cases ov SHALL be 2'b00.
REQ-027 All intermediate arithmetic SHALL use a WIDTH+1-bit partial remainder so that no carry is lost.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state IDLE, step counter 0, and y0=0, y1=0, ov=0, busy=0, done=0.
REQ-029 Reset SHALL take priority over start and SHALL abort any division in progress with no done pulse.

Configuration
REQ-030 The macro DIV_ZERO_FAST_EN SHALL select the divide-by-zero timing.
REQ-031 With DIV_ZERO_FAST_EN defined, B=0 SHALL go IDLE->DONE directly, so done is high 1 cycle after acceptance and busy is high for that single DONE cycle.
REQ-032 Without DIV_ZERO_FAST_EN, B=0 SHALL take the full WIDTH+2 latency.
REQ-033 Result values SHALL be identical with and without DIV_ZERO_FAST_EN.

Structure
REQ-034 Package alu_pkg SHALL hold the ALU opcode constants, the DIV/DIVU opcode additions (4'b1110, 4'b1111), the div state enum type, and the ov bit-index constants (OV_SIGNED=1, OV_CARRY_DZ=0).
REQ-035 One combinational sub-module div_step SHALL implement a single restoring step: inputs partial remainder, quotient and divisor; outputs next partial remainder and next quotient.

Verification
REQ-036 Unsigned: A=13, B=3, signed_op=0 -> done at cycle 6, y0=4, y1=1, ov=00.
REQ-037 Signed: A=-7 (4'b1001), B=2 -> y0=-3 (4'b1101), y1=-1 (4'b1111), ov=00.
REQ-038 Overflow: A=4'b1000, B=4'b1111, signed_op=1 -> y0=4'b1000, y1=0, ov=10.
REQ-039 Divide-by-zero: A=5, B=0 -> y0=4'hF, y1=5, ov=01; done at cycle 1 with DIV_ZERO_FAST_EN and at cycle 6 without.
REQ-040 start pulsed during CALC with A=9, B=2 -> ignored, first result unchanged; start held through the DONE cycle -> new division accepted in the following IDLE cycle.
REQ-041 rst_n low at cycle 3 of a division -> all outputs 0, no done pulse; the next start completes normally.
